// File: rtl/mux_tree_pkg.sv
// mux_tree_pkg: sizing helpers shared by the pipelined mux tree.
// Stage s (1-based) narrows the candidate set by up to STAGE_LEVELS select bits.
package mux_tree_pkg;

    localparam int DEF_WIDTH        = 64;
    localparam int DEF_N            = 32;
    localparam int DEF_STAGE_LEVELS = 2;

    function automatic int num_stages(input int n, input int sl);
        return ($clog2(n) + sl - 1) / sl;
    endfunction

    // candidates left after stage s; s=0 gives the raw input count
    function automatic int stage_width(input int n, input int sl, input int s);
        int c;
        c = s * sl;
        if (c > $clog2(n)) c = $clog2(n);
        return n >> c;
    endfunction

    function automatic int stage_levels(input int n, input int sl, input int s);
        int rem;
        rem = $clog2(n) - (s - 1) * sl;
        return (rem < sl) ? rem : sl;
    endfunction

endpackage

// File: rtl/mux_tree_stage.sv
// mux_tree_stage: one pipeline slice of the mux tree.
// Resolves LEVELS low select bits, then registers the survivors under enable.
module mux_tree_stage
    import mux_tree_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int IN_COUNT = 4,
    parameter int LEVELS   = 2,
    parameter int SEL_W    = 5,
    localparam int IW        = $clog2(IN_COUNT),
    localparam int OW        = (IW > LEVELS) ? IW - LEVELS : 1,
    localparam int OUT_COUNT = IN_COUNT >> LEVELS
) (
    input  logic                       clk,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       valid_i,
    input  logic [IN_COUNT*WIDTH-1:0]  data_i,
    input  logic [IW-1:0]              rsel_i,
    input  logic [SEL_W-1:0]           osel_i,
    output logic                       valid_o,
    output logic [OUT_COUNT*WIDTH-1:0] data_o,
    output logic [OW-1:0]              rsel_o,
    output logic [SEL_W-1:0]           osel_o
);

    logic [OUT_COUNT*WIDTH-1:0] data_d, data_q;
    logic [OW-1:0]              rsel_d, rsel_q;
    logic [SEL_W-1:0]           osel_q;
    logic                       valid_q;
    logic [LEVELS-1:0]          lsel;

    assign lsel = rsel_i[LEVELS-1:0];

    always_comb begin
        data_d = '0;
        for (int j = 0; j < OUT_COUNT; j++) begin
            data_d[j*WIDTH +: WIDTH] =
                data_i[((j << LEVELS) + int'(lsel))*WIDTH +: WIDTH];
        end
    end

    // the last stage has no residual select left to carry
    if (IW > LEVELS) begin : g_res
        assign rsel_d = rsel_i[IW-1:LEVELS];
    end else begin : g_nores
        assign rsel_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            rsel_q  <= '0;
            osel_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_d;
            rsel_q  <= rsel_d;
            osel_q  <= osel_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign rsel_o  = rsel_q;
    assign osel_o  = osel_q;

endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N:1 mux tree with valid/ready flow control.
// The whole pipe advances together; a stalled output freezes every stage.
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int N            = DEF_N,
    parameter int STAGE_LEVELS = DEF_STAGE_LEVELS,
    localparam int SEL_W       = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel
);

    localparam int L = num_stages(N, STAGE_LEVELS);

    logic advance;

    assign advance  = !out_valid | out_ready;
    assign in_ready = advance & !reset;

    for (genvar s = 0; s < L; s++) begin : g_st
        localparam int IC = stage_width(N, STAGE_LEVELS, s);
        localparam int OC = stage_width(N, STAGE_LEVELS, s + 1);
        localparam int LV = stage_levels(N, STAGE_LEVELS, s + 1);
        localparam int IW = $clog2(IC);
        localparam int OW = (IW > LV) ? IW - LV : 1;

        logic [IC*WIDTH-1:0] di;
        logic [IW-1:0]       ri;
        logic [SEL_W-1:0]    oi;
        logic                vi;
        logic [OC*WIDTH-1:0] d;
        logic [OW-1:0]       r;
        logic [SEL_W-1:0]    os;
        logic                v;

        if (s == 0) begin : g_head
            assign di = in_data;
            assign ri = in_sel;
            assign oi = in_sel;
            assign vi = in_valid;
        end else begin : g_link
            assign di = g_st[s-1].d;
            assign ri = g_st[s-1].r;
            assign oi = g_st[s-1].os;
            assign vi = g_st[s-1].v;
        end

        mux_tree_stage #(
            .WIDTH   (WIDTH),
            .IN_COUNT(IC),
            .LEVELS  (LV),
            .SEL_W   (SEL_W)
        ) u_stage (
            .clk    (clk),
            .rst_i  (reset),
            .en_i   (advance),
            .valid_i(vi),
            .data_i (di),
            .rsel_i (ri),
            .osel_i (oi),
            .valid_o(v),
            .data_o (d),
            .rsel_o (r),
            .osel_o (os)
        );
    end

    logic unused_rsel;
    assign unused_rsel = ^g_st[L-1].r;

    assign out_valid = g_st[L-1].v;
    assign out_data  = g_st[L-1].d;
    assign out_sel   = g_st[L-1].os;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed scoreboard bench for three mux tree configurations.
// A: N=32/levels 2 (L=3), B: N=16/levels 4 (L=1), C: N=8/levels 1 (L=3).
module tb_mux_tree_pipe;

    typedef struct {
        int          sel;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic          a_iv, a_ir, a_ov, a_or;
    logic [2047:0] a_id;
    logic [4:0]    a_is, a_os;
    logic [63:0]   a_od;

    logic          b_iv, b_ir, b_ov, b_or;
    logic [1023:0] b_id;
    logic [3:0]    b_is, b_os;
    logic [63:0]   b_od;

    logic          c_iv, c_ir, c_ov, c_or;
    logic [511:0]  c_id;
    logic [2:0]    c_is, c_os;
    logic [63:0]   c_od;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fa[3], fv[3], lv[3], nv[3];

    always #5 clk = ~clk;

    mux_tree_pipe #(.WIDTH(64), .N(32), .STAGE_LEVELS(2)) u_a (
        .clk(clk), .reset(rst), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .in_sel(a_is), .out_valid(a_ov),
        .out_ready(a_or), .out_data(a_od), .out_sel(a_os)
    );

    mux_tree_pipe #(.WIDTH(64), .N(16), .STAGE_LEVELS(4)) u_b (
        .clk(clk), .reset(rst), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .in_sel(b_is), .out_valid(b_ov),
        .out_ready(b_or), .out_data(b_od), .out_sel(b_os)
    );

    mux_tree_pipe #(.WIDTH(64), .N(8), .STAGE_LEVELS(1)) u_c (
        .clk(clk), .reset(rst), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .in_sel(c_is), .out_valid(c_ov),
        .out_ready(c_or), .out_data(c_od), .out_sel(c_os)
    );

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_trk();
        for (int k = 0; k < 3; k++) begin
            fa[k] = -1;
            fv[k] = -1;
            lv[k] = -1;
            nv[k] = 0;
        end
    endtask

    task automatic track(input int k, input logic acc, input logic ov);
        if (acc && fa[k] < 0) fa[k] = cyc;
        if (ov) begin
            if (fv[k] < 0) fv[k] = cyc;
            lv[k] = cyc;
            nv[k]++;
        end
    endtask

    // sample just before the edge, update scoreboards, then cross the edge
    task automatic tick();
        exp_t e;
        #1;
        track(0, a_iv && a_ir, a_ov);
        track(1, b_iv && b_ir, b_ov);
        track(2, c_iv && c_ir, c_ov);
        if (a_ov && a_or) begin
            chk("a_unexpected", 64'(qa.size() == 0), 0);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("a_data", a_od, e.data);
                chk("a_sel", 64'(a_os), 64'(e.sel));
            end
        end
        if (b_ov && b_or) begin
            chk("b_unexpected", 64'(qb.size() == 0), 0);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("b_data", b_od, e.data);
                chk("b_sel", 64'(b_os), 64'(e.sel));
            end
        end
        if (c_ov && c_or) begin
            chk("c_unexpected", 64'(qc.size() == 0), 0);
            if (qc.size() != 0) begin
                e = qc.pop_front();
                chk("c_data", c_od, e.data);
                chk("c_sel", 64'(c_os), 64'(e.sel));
            end
        end
        if (a_iv && a_ir) qa.push_back('{int'(a_is), a_id[a_is*64 +: 64]});
        if (b_iv && b_ir) qb.push_back('{int'(b_is), b_id[b_is*64 +: 64]});
        if (c_iv && c_ir) qc.push_back('{int'(c_is), c_id[c_is*64 +: 64]});
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < max) begin
            tick();
            n++;
        end
        chk("drain", 64'(qa.size() + qb.size() + qc.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] vpat;
        int         bsel[5];

        vpat = 5'b01101;
        bsel = '{3, 0, 9, 30, 0};
        for (int i = 0; i < 32; i++) a_id[i*64 +: 64] = pat(i);
        for (int i = 0; i < 16; i++) b_id[i*64 +: 64] = pat(i);
        for (int i = 0; i < 8; i++)  c_id[i*64 +: 64] = pat(i);
        rst  = 1'b1;
        a_iv = 1'b1; a_is = '0; a_or = 1'b1;
        b_iv = 1'b0; b_is = '0; b_or = 1'b1;
        c_iv = 1'b0; c_is = '0; c_or = 1'b1;
        clr_trk();

        tick();
        tick();
        chk("rst_ov", 64'(a_ov), 0);
        chk("rst_od", a_od, 0);
        chk("rst_os", 64'(a_os), 0);
        chk("rst_ir", 64'(a_ir), 0);
        rst  = 1'b0;
        a_iv = 1'b0;
        #1;
        chk("ir_after_rst", 64'(a_ir), 1);

        // full select sweep, back to back
        clr_trk();
        for (int i = 0; i < 32; i++) begin
            a_iv = 1'b1;
            a_is = 5'(i);
            tick();
        end
        a_iv = 1'b0;
        drain(10);
        chk("sweep_lat", 64'(fv[0] - fa[0]), 3);
        chk("sweep_cnt", 64'(nv[0]), 32);
        chk("sweep_run", 64'(lv[0] - fv[0] + 1), 32);

        // backpressure with sel 8 held at the input
        a_iv = 1'b1;
        a_is = 5'd5; tick();
        a_is = 5'd6; tick();
        a_is = 5'd7; tick();
        a_is = 5'd8;
        a_or = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_ov", 64'(a_ov), 1);
            chk("bp_data", a_od, pat(5));
            chk("bp_sel", 64'(a_os), 5);
            chk("bp_ir", 64'(a_ir), 0);
            tick();
        end
        a_or = 1'b1;
        clr_trk();
        tick();
        a_iv = 1'b0;
        drain(10);
        chk("bp_cnt", 64'(nv[0]), 4);
        chk("bp_run", 64'(lv[0] - fv[0] + 1), 4);

        // bubbles propagate unchanged
        for (int t = 0; t < 8; t++) begin
            if (t < 5) begin
                a_iv = vpat[t];
                a_is = 5'(bsel[t]);
            end else begin
                a_iv = 1'b0;
            end
            if (t >= 3) begin
                #1;
                chk("bub_ov", 64'(a_ov), 64'(vpat[t-3]));
            end
            tick();
        end
        drain(5);

        // inputs only matter on the accepting edge
        a_iv = 1'b1;
        a_is = 5'd17;
        tick();
        a_iv = 1'b0;
        a_is = 5'd3;
        a_id[17*64 +: 64] = 64'hDEAD_BEEF_0000_0011;
        tick();
        tick();
        chk("hold_data", a_od, pat(17));
        chk("hold_sel", 64'(a_os), 17);
        drain(5);
        a_id[17*64 +: 64] = pat(17);

        // reset while beats are in flight, all three shapes
        a_or = 1'b0; b_or = 1'b0; c_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_iv = 1'b1; a_is = 5'(k + 1);
            b_iv = 1'b1; b_is = 4'(k + 1);
            c_iv = 1'b1; c_is = 3'(k + 1);
            tick();
        end
        rst  = 1'b1;
        a_is = 5'd4; b_is = 4'd4; c_is = 3'd4;
        #1;
        chk("mid_rst_ir", 64'(a_ir), 0);
        tick();
        rst  = 1'b0;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        qa.delete(); qb.delete(); qc.delete();
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("mid_a_ov", 64'(a_ov), 0);
            chk("mid_b_ov", 64'(b_ov), 0);
            chk("mid_c_ov", 64'(c_ov), 0);
            tick();
        end
        clr_trk();
        a_iv = 1'b1; a_is = 5'd31;
        b_iv = 1'b1; b_is = 4'd15;
        c_iv = 1'b1; c_is = 3'd7;
        tick();
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        drain(8);
        chk("mid_a_lat", 64'(fv[0] - fa[0]), 3);
        chk("mid_b_lat", 64'(fv[1] - fa[1]), 1);
        chk("mid_c_lat", 64'(fv[2] - fa[2]), 3);
        chk("mid_a_cnt", 64'(nv[0]), 1);
        chk("mid_b_cnt", 64'(nv[1]), 1);
        chk("mid_c_cnt", 64'(nv[2]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
